max_pool_stream: RTL and testbench

Streaming max-pooling stage placed directly downstream of the convolver. It consumes the convolver's raster-ordered output stream of an M×M feature map, qualified by a valid strobe, and emits one pooled value per non-overlapping P×P window in raster order. A single row buffer of M/P partial maxima stores the pooled results between rows, so no frame buffer is needed. An optional ReLU can be compiled in ahead of the max.

---
 rtl/max_pool_stream_pkg.sv | 19 +
 rtl/max_pool_stream_if.sv | 24 ++
 rtl/max_pool_stream_pool_row_buffer.sv | 30 +++
 rtl/max_pool_stream.sv | 126 ++++++++++++
 tb/tb_max_pool_stream.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/max_pool_stream_pkg.sv
// Shared types and helpers for the streaming max-pool stage.
package max_pool_stream_pkg;

    localparam int unsigned DefDataWidth = 16;
    localparam int unsigned DefM         = 26;
    localparam int unsigned DefP         = 2;

    // Per-sample window event decoded by the top level.
    typedef struct packed {
        logic fire;  // last sample of a pooling window in its last row
        logic last;  // ... and that window closes the frame
    } pool_evt_t;

    // Index width for a counter covering 0..n-1, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/max_pool_stream_if.sv
// Sample stream into the pooling stage and pooled stream out of it.
interface max_pool_stream_if #(
    parameter int unsigned dataWidth = 16
) ();

    logic signed [dataWidth-1:0] data_in;
    logic                        valid_in;
    logic signed [dataWidth-1:0] data_out;
    logic                        valid_out;
    logic                        end_out;

    // Upstream producer / downstream consumer side.
    modport master (
        output data_in, valid_in,
        input  data_out, valid_out, end_out
    );

    // Pooling stage side.
    modport slave (
        input  data_in, valid_in,
        output data_out, valid_out, end_out
    );

endinterface

// File: rtl/max_pool_stream_pool_row_buffer.sv
// Pool row buffer: one partial column maximum per pooling window across a row.
// Single index serves both the synchronous write and the combinational read.
// No reset: every entry is rewritten by the first row of each window band.
module max_pool_stream_pool_row_buffer #(
    parameter int unsigned dataWidth = 16,
    parameter int unsigned Depth     = 13,
    parameter int unsigned IdxWidth  = 4
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [IdxWidth-1:0]         k,
    input  logic signed [dataWidth-1:0] wdata,
    output logic signed [dataWidth-1:0] rdata
);

    logic signed [dataWidth-1:0] mem [Depth];

    // Store the partial maximum for window column k.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[k] <= wdata;
        end
    end

    // Combinational read of the same entry being updated.
    always_comb begin
        rdata = mem[k];
    end

endmodule

// File: rtl/max_pool_stream.sv
// Streaming P x P non-overlapping max pooling over an M x M raster stream.
// Optional build macro: RELU_EN clamps negative samples to zero ahead of the max.
module max_pool_stream
    import max_pool_stream_pkg::*;
#(
    parameter int unsigned dataWidth = DefDataWidth,
    parameter int unsigned M         = DefM,
    parameter int unsigned P         = DefP
) (
    input  logic             clk,
    input  logic             global_rst,
    input  logic             ce,
    max_pool_stream_if.slave bus
);

    localparam int unsigned NP = M / P;
    localparam int unsigned CW = idx_width(M);
    localparam int unsigned PW = idx_width(P);
    localparam int unsigned KW = idx_width(NP);

    // Last index of the pooled region; columns/rows past it are discarded.
    localparam logic [CW-1:0] ActLast = CW'(NP * P - 1);
    localparam logic [CW-1:0] MLast   = CW'(M - 1);
    localparam logic [PW-1:0] PLast   = PW'(P - 1);
    localparam logic [KW-1:0] KLast   = KW'(NP - 1);

    function automatic logic signed [dataWidth-1:0] smax(
        input logic signed [dataWidth-1:0] a,
        input logic signed [dataWidth-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    logic [CW-1:0] c_q, r_q;
    logic [PW-1:0] hp_q, vp_q;
    logic [KW-1:0] k_q;
    logic signed [dataWidth-1:0] h_q;
    logic signed [dataWidth-1:0] data_out_q;
    logic valid_q, end_q;

    logic acc, active, win_end, buf_we;
    logic signed [dataWidth-1:0] x, h_new, buf_rd, combined;
    pool_evt_t evt;

    // Pre-op, horizontal max and vertical combine for the current sample.
    always_comb begin
        acc = ce & bus.valid_in;
`ifdef RELU_EN
        x = bus.data_in[dataWidth-1] ? '0 : bus.data_in;
`else
        x = bus.data_in;
`endif
        h_new    = (hp_q == '0) ? x : smax(h_q, x);
        active   = (c_q <= ActLast) && (r_q <= ActLast);
        win_end  = acc && active && (hp_q == PLast);
        combined = (vp_q == '0) ? h_new : smax(buf_rd, h_new);
        buf_we   = win_end && (vp_q != PLast);
        evt.fire = win_end && (vp_q == PLast);
        evt.last = evt.fire && (c_q == ActLast) && (r_q == ActLast);
    end

    max_pool_stream_pool_row_buffer #(
        .dataWidth (dataWidth),
        .Depth     (NP),
        .IdxWidth  (KW)
    ) u_row_buf (
        .clk   (clk),
        .we    (buf_we),
        .k     (k_q),
        .wdata (combined),
        .rdata (buf_rd)
    );

    // Raster position, window phases and the running horizontal max.
    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            c_q  <= '0;
            r_q  <= '0;
            hp_q <= '0;
            vp_q <= '0;
            k_q  <= '0;
            h_q  <= '0;
        end else if (acc) begin
            h_q <= h_new;
            if (c_q == MLast) begin
                // Row wrap also realigns the phases when M is not a multiple of P.
                c_q  <= '0;
                hp_q <= '0;
                k_q  <= '0;
                if (r_q == MLast) begin
                    r_q  <= '0;
                    vp_q <= '0;
                end else begin
                    r_q  <= r_q + CW'(1);
                    vp_q <= (vp_q == PLast) ? '0 : vp_q + PW'(1);
                end
            end else begin
                c_q  <= c_q + CW'(1);
                hp_q <= (hp_q == PLast) ? '0 : hp_q + PW'(1);
                if ((hp_q == PLast) && (k_q != KLast)) begin
                    k_q <= k_q + KW'(1);
                end
            end
        end
    end

    // Registered outputs; strobes drop on the next edge whatever ce does.
    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            data_out_q <= '0;
            valid_q    <= 1'b0;
            end_q      <= 1'b0;
        end else begin
            valid_q <= evt.fire;
            end_q   <= evt.last;
            if (evt.fire) begin
                data_out_q <= combined;
            end
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_q;
    assign bus.end_out   = end_q;

endmodule

// File: tb/tb_max_pool_stream.sv
// Directed bench for max_pool_stream: an M=4 and an M=5 instance, both with P=2.
module tb_max_pool_stream;

    logic clk = 1'b0;
    logic rst;
    logic ce;

    always #5 clk = ~clk;

    max_pool_stream_if #(.dataWidth(16)) if4 ();
    max_pool_stream_if #(.dataWidth(16)) if5 ();

    max_pool_stream #(.dataWidth(16), .M(4), .P(2)) dut4 (
        .clk        (clk),
        .global_rst (rst),
        .ce         (ce),
        .bus        (if4)
    );

    max_pool_stream #(.dataWidth(16), .M(5), .P(2)) dut5 (
        .clk        (clk),
        .global_rst (rst),
        .ce         (ce),
        .bus        (if5)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic signed [15:0] q4_d[$];
    logic               q4_e[$];
    logic signed [15:0] q5_d[$];
    logic               q5_e[$];
    int                 exp_d[$];
    bit                 exp_e[$];

    // Collect every pooled output away from the active edge.
    always @(negedge clk) begin
        if (if4.valid_out === 1'b1) begin
            q4_d.push_back(if4.data_out);
            q4_e.push_back(if4.end_out);
        end
        if (if5.valid_out === 1'b1) begin
            q5_d.push_back(if5.data_out);
            q5_e.push_back(if5.end_out);
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step4(input logic signed [15:0] v);
        if4.data_in  = v;
        if4.valid_in = 1'b1;
        @(posedge clk);
        #1;
        if4.valid_in = 1'b0;
    endtask

    task automatic step5(input logic signed [15:0] v);
        if5.data_in  = v;
        if5.valid_in = 1'b1;
        @(posedge clk);
        #1;
        if5.valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        q4_d.delete();
        q4_e.delete();
        q5_d.delete();
        q5_e.delete();
    endtask

    // Compare collected outputs of one instance against exp_d/exp_e, then clear.
    task automatic chk_stream(input string tag, input bit sel);
        logic signed [15:0] got_d[$];
        logic               got_e[$];
        if (sel) begin
            got_d = q5_d;
            got_e = q5_e;
        end else begin
            got_d = q4_d;
            got_e = q4_e;
        end
        chk({tag, " count"}, got_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            chk($sformatf("%s data[%0d]", tag, i), got_d[i], exp_d[i]);
            chk($sformatf("%s end[%0d]", tag, i), got_e[i], exp_e[i]);
        end
        clear_q();
    endtask

    initial begin
        bit is_out;
        rst          = 1'b1;
        ce           = 1'b1;
        if4.data_in  = '0;
        if4.valid_in = 1'b0;
        if5.data_in  = '0;
        if5.valid_in = 1'b0;

        // Reset state
        #12;
        chk("reset data4", if4.data_out, 0);
        chk("reset valid4", if4.valid_out, 0);
        chk("reset end4", if4.end_out, 0);
        chk("reset data5", if5.data_out, 0);
        chk("reset valid5", if5.valid_out, 0);
        chk("reset end5", if5.end_out, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // Continuous ramp with cycle-exact latency checks
        for (int i = 0; i < 16; i++) begin
            step4(16'(i));
            is_out = (i == 5) || (i == 7) || (i == 13) || (i == 15);
            chk($sformatf("ramp valid@%0d", i), if4.valid_out, is_out);
            if (is_out) begin
                chk($sformatf("ramp data@%0d", i), if4.data_out, i);
                chk($sformatf("ramp end@%0d", i), if4.end_out, i == 15);
            end
        end
        idle(1);
        chk("ramp valid drop", if4.valid_out, 0);
        chk("ramp end drop", if4.end_out, 0);
        chk("ramp data hold", if4.data_out, 15);
        exp_d = '{5, 7, 13, 15};
        exp_e = '{0, 0, 0, 1};
        chk_stream("ramp", 1'b0);

        // Negative ramp -1..-16
        for (int i = 0; i < 16; i++) begin
            step4(16'(-(i + 1)));
        end
        idle(1);
`ifdef RELU_EN
        exp_d = '{0, 0, 0, 0};
`else
        exp_d = '{-1, -3, -9, -11};
`endif
        exp_e = '{0, 0, 0, 1};
        chk_stream("neg", 1'b0);

        // Sparse valid plus a ce=0 stall mid-row with valid_in held high
        for (int i = 0; i < 16; i++) begin
            step4(16'(i));
            if (i == 6) begin
                ce           = 1'b0;
                if4.valid_in = 1'b1;
                if4.data_in  = 16'sd999;
                for (int j = 0; j < 3; j++) begin
                    @(posedge clk);
                    #1;
                    chk($sformatf("stall data[%0d]", j), if4.data_out, 5);
                    chk($sformatf("stall valid[%0d]", j), if4.valid_out, 0);
                end
                ce           = 1'b1;
                if4.valid_in = 1'b0;
            end
            idle(1);
        end
        exp_d = '{5, 7, 13, 15};
        exp_e = '{0, 0, 0, 1};
        chk_stream("gaps", 1'b0);

        // M=5: last row and column fall outside the pooled region
        for (int i = 0; i < 25; i++) begin
            step5(16'(i));
        end
        idle(1);
        exp_d = '{6, 8, 16, 18};
        exp_e = '{0, 0, 0, 1};
        chk_stream("m5", 1'b1);

        // Asynchronous reset mid-frame, then a clean frame
        for (int i = 0; i < 7; i++) begin
            step4(16'(i));
        end
        chk("pre-reset data", if4.data_out, 5);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst data", if4.data_out, 0);
        chk("async rst valid", if4.valid_out, 0);
        chk("async rst end", if4.end_out, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        idle(1);
        clear_q();
        for (int i = 0; i < 16; i++) begin
            step4(16'(i));
        end
        idle(1);
        exp_d = '{5, 7, 13, 15};
        exp_e = '{0, 0, 0, 1};
        chk_stream("post-rst", 1'b0);

        // Two frames back-to-back
        for (int i = 0; i < 16; i++) begin
            step4(16'(i));
        end
        for (int i = 0; i < 16; i++) begin
            step4(16'(100 + i));
        end
        idle(1);
        exp_d = '{5, 7, 13, 15, 105, 107, 113, 115};
        exp_e = '{0, 0, 0, 1, 0, 0, 0, 1};
        chk_stream("b2b", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
